// File: rtl/lc3_rf_pkg.sv
// Shared definitions for the register-file write-back path.
//   ADDR_W / NREG : default register address width and register count
//   onehot()      : address to one-hot vector for the default register count
//   clog2()       : ceiling log2, usable in constant expressions
package lc3_rf_pkg;

  localparam int ADDR_W = 3;
  localparam int NREG   = 1 << ADDR_W;

  function automatic logic [NREG-1:0] onehot(input logic [ADDR_W-1:0] addr);
    return NREG'(1) << addr;
  endfunction

  // Result is at least 1 so it can always be used as a vector width.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/rf_onehot_dec.sv
// Combinational address to one-hot decoder with enable.
//   en_i   : when low the output is all zeros
//   addr_i : register address
//   dec_o  : one-hot vector, bit addr_i set when enabled
module rf_onehot_dec #(
  parameter int ADDR_W = 3,
  parameter int NREG   = 8
) (
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [NREG-1:0]   dec_o
);

  always_comb begin
    dec_o = '0;
    if (en_i) dec_o[addr_i] = 1'b1;
  end

endmodule

// File: rtl/reg_wr_scoreboard.sv
// Write-back decoder plus pending-write scoreboard for the register file.
//   clk, reset            : clock, synchronous active-high reset
//   issue_valid/addr      : control side marks a destination register pending
//   issue_ready           : combinational accept for the current issue request
//   wb_valid/addr         : write-back of a destination register
//   wb_we                 : registered one-hot write enable, one cycle per write-back
//   busy                  : registered pending bits
//   rd_addr_a/b, rd_busy_a/b : source operand pending lookups (no bypass)
//   out_cnt               : registered number of pending writes
//   wb_err                : sticky, write-back to a register that was not pending
module reg_wr_scoreboard #(
  parameter int ADDR_W  = lc3_rf_pkg::ADDR_W,
  parameter int NREG    = lc3_rf_pkg::NREG,
  parameter int MAX_OUT = 4,
  parameter bit BYPASS  = 1'b0
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   issue_valid,
  input  logic [ADDR_W-1:0]                      issue_addr,
  output logic                                   issue_ready,
  input  logic                                   wb_valid,
  input  logic [ADDR_W-1:0]                      wb_addr,
  output logic [NREG-1:0]                        wb_we,
  output logic [NREG-1:0]                        busy,
  input  logic [ADDR_W-1:0]                      rd_addr_a,
  input  logic [ADDR_W-1:0]                      rd_addr_b,
  output logic                                   rd_busy_a,
  output logic                                   rd_busy_b,
  output logic [lc3_rf_pkg::clog2(MAX_OUT+1)-1:0] out_cnt,
  output logic                                   wb_err
);

  import lc3_rf_pkg::*;

  localparam int CNT_W = clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

  logic [NREG-1:0]  wb_we_q, wb_we_d;
  logic [NREG-1:0]  busy_q, busy_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             wb_err_q, wb_err_d;

  logic [NREG-1:0]  clear_mask, busy_eff, set_mask;
  logic             wb_clear, issue_fire;

  rf_onehot_dec #(.ADDR_W(ADDR_W), .NREG(NREG)) u_wb_dec (
    .en_i   (wb_valid),
    .addr_i (wb_addr),
    .dec_o  (wb_we_d)
  );

  rf_onehot_dec #(.ADDR_W(ADDR_W), .NREG(NREG)) u_set_dec (
    .en_i   (issue_fire),
    .addr_i (issue_addr),
    .dec_o  (set_mask)
  );

  // Only a write-back that hits a pending register frees a slot.
  assign clear_mask = wb_we_d & busy_q;
  assign wb_clear   = |clear_mask;
  assign busy_eff   = BYPASS ? (busy_q & ~clear_mask) : busy_q;

  // The outstanding limit admits an issue whenever a slot frees this cycle,
  // independent of BYPASS; BYPASS only affects the same-register check.
  assign issue_ready = !busy_eff[issue_addr] && ((out_cnt_q < MAX_CNT) || wb_clear);
  assign issue_fire  = issue_valid && issue_ready;

  // Clear before set so a same-cycle issue to the freed register keeps it pending.
  assign busy_d    = (busy_q & ~clear_mask) | set_mask;
  assign out_cnt_d = out_cnt_q + CNT_W'(issue_fire) - CNT_W'(wb_clear);
  assign wb_err_d  = wb_err_q | (wb_valid && !wb_clear);

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_we_q   <= '0;
      busy_q    <= '0;
      out_cnt_q <= '0;
      wb_err_q  <= 1'b0;
    end else begin
      wb_we_q   <= wb_we_d;
      busy_q    <= busy_d;
      out_cnt_q <= out_cnt_d;
      wb_err_q  <= wb_err_d;
    end
  end

  assign wb_we     = wb_we_q;
  assign busy      = busy_q;
  assign out_cnt   = out_cnt_q;
  assign wb_err    = wb_err_q;
  assign rd_busy_a = busy_q[rd_addr_a];
  assign rd_busy_b = busy_q[rd_addr_b];

  a_cnt_matches_busy: assert property (@(posedge clk) disable iff (reset)
    $countones(busy_q) == int'(out_cnt_q));

endmodule

// File: tb/tb_reg_wr_scoreboard.sv
module tb_reg_wr_scoreboard;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       issue_valid = 1'b0;
  logic [2:0] issue_addr = '0;
  logic       wb_valid = 1'b0;
  logic [2:0] wb_addr = '0;
  logic [2:0] rd_addr_a = '0;
  logic [2:0] rd_addr_b = '0;

  logic       rdy [2];
  logic [7:0] we  [2];
  logic [7:0] bsy [2];
  logic       rba [2];
  logic       rbb [2];
  logic [2:0] cnt [2];
  logic       err [2];

  always #5 clk = ~clk;

  reg_wr_scoreboard #(.ADDR_W(3), .NREG(8), .MAX_OUT(4), .BYPASS(1'b0)) u_nobyp (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(rdy[0]),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_we(we[0]), .busy(bsy[0]),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_busy_a(rba[0]), .rd_busy_b(rbb[0]),
    .out_cnt(cnt[0]), .wb_err(err[0])
  );

  reg_wr_scoreboard #(.ADDR_W(3), .NREG(8), .MAX_OUT(4), .BYPASS(1'b1)) u_byp (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(rdy[1]),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_we(we[1]), .busy(bsy[1]),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_busy_a(rba[1]), .rd_busy_b(rbb[1]),
    .out_cnt(cnt[1]), .wb_err(err[1])
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%0h want=%0h at %0t", nm, d, act, exp, $time);
    end
  endtask

  // Model: index 0 has no bypass, index 1 has bypass; limit of 4 pending.
  bit         mbusy [2][8];
  int         mcnt  [2];
  logic [7:0] mwe   [2];
  bit         merr  [2];
  bit         m_rdy;

  function automatic logic [7:0] mvec(input int d);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = mbusy[d][i];
    return v;
  endfunction

  function automatic bit mready(input int d);
    bit hit_free, blocked;
    hit_free = wb_valid && mbusy[d][wb_addr];
    blocked  = mbusy[d][issue_addr] && !(d == 1 && hit_free && wb_addr == issue_addr);
    return !blocked && (mcnt[d] < 4 || hit_free);
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      m_rdy = mready(d);
      if (reset) begin
        for (int i = 0; i < 8; i++) mbusy[d][i] = 1'b0;
        mcnt[d] = 0;
        mwe[d]  = 8'h00;
        merr[d] = 1'b0;
      end else begin
        mwe[d] = 8'h00;
        if (wb_valid) begin
          mwe[d][wb_addr] = 1'b1;
          if (mbusy[d][wb_addr]) begin
            mbusy[d][wb_addr] = 1'b0;
            mcnt[d] = mcnt[d] - 1;
          end else begin
            merr[d] = 1'b1;
          end
        end
        if (issue_valid && m_rdy) begin
          mbusy[d][issue_addr] = 1'b1;
          mcnt[d] = mcnt[d] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk("m_issue_ready", d, 32'(rdy[d]), 32'(mready(d)));
      chk("m_wb_we",       d, 32'(we[d]),  32'(mwe[d]));
      chk("m_busy",        d, 32'(bsy[d]), 32'(mvec(d)));
      chk("m_out_cnt",     d, 32'(cnt[d]), 32'(mcnt[d]));
      chk("m_wb_err",      d, 32'(err[d]), 32'(merr[d]));
      chk("m_rd_busy_a",   d, 32'(rba[d]), 32'(mbusy[d][rd_addr_a]));
      chk("m_rd_busy_b",   d, 32'(rbb[d]), 32'(mbusy[d][rd_addr_b]));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit iv, input logic [2:0] ia, input bit wv, input logic [2:0] wa);
    issue_valid = iv;
    issue_addr  = ia;
    wb_valid    = wv;
    wb_addr     = wa;
  endtask

  task automatic idle;
    drive(1'b0, 3'd0, 1'b0, 3'd0);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("rst_wb_we", 0, 32'(we[0]), 32'h00);
    chk("rst_busy",  0, 32'(bsy[0]), 32'h00);
    chk("rst_cnt",   0, 32'(cnt[0]), 32'd0);
    chk("rst_err",   0, 32'(err[0]), 32'd0);

    // write-back to an idle register
    drive(1'b0, 3'd0, 1'b1, 3'd5);
    tick();
    idle();
    chk("dec_r5",      0, 32'(we[0]),  32'h20);
    chk("err_r5",      0, 32'(err[0]), 32'd1);
    chk("busy_r5",     0, 32'(bsy[0]), 32'h00);
    tick();
    chk("dec_r5_end",  0, 32'(we[0]),  32'h00);
    chk("err_sticky",  0, 32'(err[0]), 32'd1);

    // issue R3, WAW block, write-back R3
    do_reset();
    drive(1'b1, 3'd3, 1'b0, 3'd0);
    #1 chk("rdy_r3", 0, 32'(rdy[0]), 32'd1);
    tick();
    idle();
    chk("busy_r3", 0, 32'(bsy[0]), 32'h08);
    chk("cnt_r3",  0, 32'(cnt[0]), 32'd1);
    drive(1'b1, 3'd3, 1'b0, 3'd0);
    #1;
    chk("waw_r3", 0, 32'(rdy[0]), 32'd0);
    chk("waw_r3", 1, 32'(rdy[1]), 32'd0);
    tick();
    chk("busy_r3_hold", 0, 32'(bsy[0]), 32'h08);
    drive(1'b0, 3'd0, 1'b1, 3'd3);
    tick();
    idle();
    chk("wb_r3_we",   0, 32'(we[0]),  32'h08);
    chk("wb_r3_busy", 0, 32'(bsy[0]), 32'h00);
    chk("wb_r3_cnt",  0, 32'(cnt[0]), 32'd0);
    chk("wb_r3_err",  0, 32'(err[0]), 32'd0);

    // fill to the outstanding limit
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'(i), 1'b0, 3'd0);
      tick();
    end
    idle();
    chk("full_cnt",  0, 32'(cnt[0]), 32'd4);
    chk("full_busy", 0, 32'(bsy[0]), 32'h0F);
    drive(1'b1, 3'd4, 1'b0, 3'd0);
    #1 chk("full_rdy_r4", 0, 32'(rdy[0]), 32'd0);
    tick();
    chk("full_busy_hold", 0, 32'(bsy[0]), 32'h0F);
    drive(1'b1, 3'd4, 1'b1, 3'd1);
    #1;
    chk("full_wb_rdy", 0, 32'(rdy[0]), 32'd1);
    chk("full_wb_rdy", 1, 32'(rdy[1]), 32'd1);
    tick();
    idle();
    for (int d = 0; d < 2; d++) begin
      chk("swap_busy", d, 32'(bsy[d]), 32'h1D);
      chk("swap_cnt",  d, 32'(cnt[d]), 32'd4);
    end

    // same-register issue and write-back, limit reached
    drive(1'b1, 3'd2, 1'b1, 3'd2);
    #1;
    chk("same_rdy_byp",   1, 32'(rdy[1]), 32'd1);
    chk("same_rdy_nobyp", 0, 32'(rdy[0]), 32'd0);
    tick();
    idle();
    chk("same_busy_byp",   1, 32'(bsy[1]), 32'h1D);
    chk("same_cnt_byp",    1, 32'(cnt[1]), 32'd4);
    chk("same_we_byp",     1, 32'(we[1]),  32'h04);
    chk("same_busy_nobyp", 0, 32'(bsy[0]), 32'h19);
    chk("same_cnt_nobyp",  0, 32'(cnt[0]), 32'd3);

    // operand lookups
    do_reset();
    drive(1'b1, 3'd6, 1'b0, 3'd0);
    tick();
    idle();
    rd_addr_a = 3'd6;
    rd_addr_b = 3'd1;
    #1;
    chk("rd_busy_vec", 0, 32'(bsy[0]), 32'h40);
    chk("rd_busy_a",   0, 32'(rba[0]), 32'd1);
    chk("rd_busy_b",   0, 32'(rbb[0]), 32'd0);

    // reset coincident with a pending write-back
    do_reset();
    drive(1'b1, 3'd7, 1'b0, 3'd0);
    tick();
    chk("r7_busy", 0, 32'(bsy[0]), 32'h80);
    reset = 1'b1;
    drive(1'b0, 3'd0, 1'b1, 3'd7);
    tick();
    reset = 1'b0;
    idle();
    chk("rst_wb_busy", 0, 32'(bsy[0]), 32'h00);
    chk("rst_wb_cnt",  0, 32'(cnt[0]), 32'd0);
    chk("rst_wb_we",   0, 32'(we[0]),  32'h00);
    chk("rst_wb_err",  0, 32'(err[0]), 32'd0);
    tick();
    chk("rst_wb_we2",  0, 32'(we[0]),  32'h00);

    // mixed traffic checked by the model on every cycle
    for (int n = 0; n < 120; n++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      rd_addr_a = 3'($urandom_range(0, 7));
      rd_addr_b = 3'($urandom_range(0, 7));
      reset = ($urandom_range(0, 39) == 0);
      tick();
    end
    reset = 1'b0;
    idle();
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_wr_scoreboard.md
Name: reg_wr_scoreboard

Overview:
- Parametrised successor to the register-file address decoder.
- Decodes an ADDR_W-bit write-back address into a registered one-hot write-enable vector for an NREG-entry register file.
- Tracks per-register pending-write (busy) bits in a scoreboard, set on instruction issue and cleared on write-back.
- Sits between the control FSM (issue side) and the register file (write-back side). It stalls issue on write-after-write hazards and on the outstanding-write limit.

Parameters:
- ADDR_W, 3, register address width.
- NREG, 8, number of registers; must equal 2**ADDR_W.
- MAX_OUT, 4, maximum simultaneously pending writes; range 1..NREG.
- BYPASS, 0, when 1 a write-back in the same cycle frees its register for a same-cycle issue.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- issue_valid  in  1  control requests to mark a destination register pending.
- issue_addr  in  ADDR_W  destination register of the issuing instruction.
- issue_ready  out  1  issue accepted this cycle when high together with issue_valid; combinational.
- wb_valid  in  1  write-back data present this cycle.
- wb_addr  in  ADDR_W  write-back destination register.
- wb_we  out  NREG  registered one-hot write enable to the register file.
- busy  out  NREG  scoreboard pending bits, registered.
- rd_addr_a  in  ADDR_W  source operand A address.
- rd_addr_b  in  ADDR_W  source operand B address.
- rd_busy_a  out  1  busy[rd_addr_a], combinational.
- rd_busy_b  out  1  busy[rd_addr_b], combinational.
- out_cnt  out  clog2(MAX_OUT+1)  number of pending writes, registered.
- wb_err  out  1  sticky flag: write-back to a non-busy register.

Behaviour:
- Reset (synchronous): wb_we=0, busy=0, out_cnt=0, wb_err=0. reset overrides every same-cycle event.
- Decode: the cycle after wb_valid=1, wb_we = 1<<wb_addr (exactly one bit set). Latency is 1 cycle. When wb_valid=0, wb_we=0 next cycle. No latch or hold: wb_we is high for exactly one cycle per write-back.
- Issue acceptance: issue_ready = !busy_eff[issue_addr] && (out_cnt < MAX_OUT || wb_clear).
  - busy_eff = busy when BYPASS=0.
  - busy_eff = busy & ~clear_mask when BYPASS=1.
  - clear_mask = wb_valid ? (1<<wb_addr) & busy : 0.
  - wb_clear = |clear_mask.
  - issue_ready does not depend on issue_valid.
- Accepted issue (issue_valid && issue_ready) sets busy[issue_addr] next cycle.
- Write-back to a busy register clears that busy bit next cycle.
- Write-back to a non-busy register: wb_we is still generated, busy is unchanged, and wb_err is set and held until reset.
- Simultaneous issue and write-back to the same register (BYPASS=1): set wins, bit stays 1, out_cnt unchanged. With BYPASS=0, issue_ready is low and the write-back clears the bit.
- out_cnt next value = out_cnt + accepted_issue - wb_clear. It never exceeds MAX_OUT and never underflows.
- At out_cnt==MAX_OUT, issue_ready=0 unless wb_clear=1 the same cycle. The outstanding limit always permits issue-with-clear regardless of BYPASS, as long as the address check passes.
- Invariant: popcount(busy)==out_cnt at every clock edge; assertion-checked.
- rd_busy_a/b read the registered busy vector with no bypass, so forwarding is not the scoreboard's job.
- Reset asserted while registers are pending: all pending state is discarded; no wb_we pulse is emitted.

Decomposition:
- Shared package lc3_rf_pkg: ADDR_W, NREG, function onehot(addr) returning NREG bits, clog2 helper.
- One sub-module, rf_onehot_dec (parametrised ADDR_W to NREG combinational decoder with enable). It is instantiated twice: for wb_we generation and for the issue set mask.
- Scoreboard, counter and error flag stay in the top module.

Test Plan:
- Reset, then wb_valid=1, wb_addr=5 for one cycle -> next cycle wb_we=8'b0010_0000, following cycle 0; wb_err=1 (R5 not busy).
- Issue R3 -> busy=8'h08, out_cnt=1. Issue R3 again -> issue_ready=0. wb R3 -> wb_we=8'h08, busy=0, out_cnt=0, wb_err=0.
- MAX_OUT=4: issue R0..R3 on consecutive cycles -> out_cnt=4. Issue R4 -> issue_ready=0. Same cycle as wb R1 -> R4 accepted, busy=8'h1D, out_cnt=4.
- BYPASS=1, R2 busy: issue R2 and wb R2 same cycle -> issue_ready=1, busy[2] stays 1, out_cnt unchanged, wb_we=8'h04.
- rd_addr_a=6 and rd_addr_b=1 with busy=8'h40 -> rd_busy_a=1, rd_busy_b=0.
- Issue R7, then assert reset for one cycle coincident with wb R7 -> busy=0, out_cnt=0, wb_we=0 after reset; wb_err=0.
